// File: rtl/demux132_capture.sv
// Serial-to-parallel 1-to-WIDTH bit demux with frame capture; stream (pointer) or addressed (sel) writes.
// Latency: 1 cycle input beat to out. Backpressure: wr_ready drops while a full frame waits for out_ack.
// Optional readback port (rb_sel/rb_bit) is built when DEMUX132_READBACK_EN is defined.
module demux132_capture #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto_inc,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             frame_done,
  input  logic             out_ack,
  output logic [SEL_W:0]   fill_cnt,
  output logic             sel_err
`ifdef DEMUX132_READBACK_EN
  ,
  input  logic [SEL_W-1:0] rb_sel,
  output logic             rb_bit
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  localparam logic [SEL_W:0]   CNT_FULL = (SEL_W+1)'(WIDTH);
  localparam logic [SEL_W:0]   CNT_ONE  = (SEL_W+1)'(1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(WIDTH-1);
  localparam logic [SEL_W-1:0] PTR_ONE  = SEL_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W:0]     cnt_q, cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               sel_err_q, sel_err_d;

  logic [SEL_W-1:0]   target;
  logic [WIDTH-1:0]   hit;
  logic               in_range;
  logic               is_new;
  logic               accept;

  // One-hot decode of the target; an index >= WIDTH decodes to all-zero.
  always_comb begin
    target = auto_inc ? ptr_q : sel;
    hit    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = (target == SEL_W'(i));
    end
    in_range = |hit;
    is_new   = |(hit & ~mask_q);
  end

  assign wr_ready = (state_q != S_FULL);
  assign accept   = wr_valid & wr_ready;

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    mask_d       = mask_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    sel_err_d    = 1'b0;

    if (clear) begin
      out_d   = '0;
      mask_d  = '0;
      ptr_d   = '0;
      cnt_d   = '0;
      state_d = S_EMPTY;
    end else if (state_q == S_FULL) begin
      // Release keeps out intact; the next frame overwrites it bit by bit.
      if (out_ack) begin
        mask_d  = '0;
        ptr_d   = '0;
        cnt_d   = '0;
        state_d = S_EMPTY;
      end
    end else if (accept) begin
      out_d  = (out_q & ~hit) | ({WIDTH{in_bit}} & hit);
      mask_d = mask_q | hit;
      if (auto_inc) begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
      end else begin
        sel_err_d = ~in_range;
      end
      if (is_new) begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q + CNT_ONE == CNT_FULL) begin
          state_d      = S_FULL;
          frame_done_d = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      out_q        <= '0;
      mask_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign out        = out_q;
  assign full       = (state_q == S_FULL);
  assign frame_done = frame_done_q;
  assign fill_cnt   = cnt_q;
  assign sel_err    = sel_err_q;

`ifdef DEMUX132_READBACK_EN
  logic rb_bit_q, rb_bit_d;

  always_comb begin
    rb_bit_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rb_sel == SEL_W'(i)) rb_bit_d = out_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rb_bit_q <= 1'b0;
    else     rb_bit_q <= rb_bit_d;
  end

  assign rb_bit = rb_bit_q;
`endif

endmodule

// File: tb/tb_demux132_capture.sv
// Directed bench for demux132_capture: a 32-bit instance for streaming/addressed/abort cases
// and a 24-bit instance for the out-of-range select case.
module tb_demux132_capture;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, clear, in_bit, auto_inc, wr_valid, out_ack;
  logic [4:0]  sel;
  logic        wr_ready, full, frame_done, sel_err;
  logic [31:0] out;
  logic [5:0]  fill_cnt;
  logic [4:0]  rb_sel;
  logic        rb_bit;

  // 24-bit instance
  logic        b_rst, b_clear, b_in_bit, b_auto_inc, b_wr_valid, b_out_ack;
  logic [4:0]  b_sel;
  logic        b_wr_ready, b_full, b_frame_done, b_sel_err;
  logic [23:0] b_out;
  logic [5:0]  b_fill_cnt;
  logic [4:0]  b_rb_sel;
  logic        b_rb_bit;

  int total = 0;
  int bad   = 0;
  logic [31:0] word;

  demux132_capture #(.WIDTH(32), .SEL_W(5)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_bit(in_bit), .sel(sel),
    .auto_inc(auto_inc), .wr_valid(wr_valid), .wr_ready(wr_ready), .out(out),
    .full(full), .frame_done(frame_done), .out_ack(out_ack),
    .fill_cnt(fill_cnt), .sel_err(sel_err)
`ifdef DEMUX132_READBACK_EN
    , .rb_sel(rb_sel), .rb_bit(rb_bit)
`endif
  );

  demux132_capture #(.WIDTH(24), .SEL_W(5)) dut24 (
    .clk(clk), .rst(b_rst), .clear(b_clear), .in_bit(b_in_bit), .sel(b_sel),
    .auto_inc(b_auto_inc), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .out(b_out),
    .full(b_full), .frame_done(b_frame_done), .out_ack(b_out_ack),
    .fill_cnt(b_fill_cnt), .sel_err(b_sel_err)
`ifdef DEMUX132_READBACK_EN
    , .rb_sel(b_rb_sel), .rb_bit(b_rb_bit)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic ai, input logic [4:0] s, input logic b);
    wr_valid = 1'b1; auto_inc = ai; sel = s; in_bit = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic beat24(input logic [4:0] s, input logic b);
    b_wr_valid = 1'b1; b_auto_inc = 1'b0; b_sel = s; b_in_bit = b;
    tick();
    b_wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_bit = 1'b0; auto_inc = 1'b0; wr_valid = 1'b0;
    out_ack = 1'b0; sel = '0; rb_sel = '0;
    b_rst = 1'b1; b_clear = 1'b0; b_in_bit = 1'b0; b_auto_inc = 1'b0; b_wr_valid = 1'b0;
    b_out_ack = 1'b0; b_sel = '0; b_rb_sel = '0;
    tick(); tick();
    rst = 1'b0; b_rst = 1'b0;

    chk("rst_out", out, 0);
    chk("rst_full", full, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sel_err", sel_err, 0);

    // Stream frame, LSB first
    word = 32'h333ac321;
    for (int i = 0; i < 31; i++) beat(1'b1, 5'd0, word[i]);
    chk("stream_fill31", fill_cnt, 31);
    chk("stream_full31", full, 0);
    chk("stream_done31", frame_done, 0);
    beat(1'b1, 5'd0, word[31]);
    chk("stream_out", out, 32'h333ac321);
    chk("stream_fill32", fill_cnt, 32);
    chk("stream_full", full, 1);
    chk("stream_done_pulse", frame_done, 1);
    chk("stream_wr_ready", wr_ready, 0);
    beat(1'b1, 5'd0, 1'b0);
    chk("stream_done_once", frame_done, 0);
    beat(1'b0, 5'd4, 1'b0);
    chk("full_extra_out", out, 32'h333ac321);
    chk("full_extra_fill", fill_cnt, 32);
    chk("full_held", full, 1);
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    chk("ack_full", full, 0);
    chk("ack_fill", fill_cnt, 0);
    chk("ack_out_kept", out, 32'h333ac321);
    chk("ack_wr_ready", wr_ready, 1);

    // Addressed writes from a cleared word
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_out", out, 0);
    beat(1'b0, 5'd6, 1'b1);
    chk("addr6_fill", fill_cnt, 1);
    out_ack = 1'b1;
    beat(1'b0, 5'd30, 1'b1);
    out_ack = 1'b0;
    chk("addr30_out", out, 32'h40000040);
    chk("addr30_fill", fill_cnt, 2);
    chk("addr30_full", full, 0);
    beat(1'b0, 5'd6, 1'b0);
    chk("rewrite_out", out, 32'h40000000);
    chk("rewrite_fill", fill_cnt, 2);
    chk("addr_sel_err", sel_err, 0);

    // Mid-frame abort with clear
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 10; i++) beat(1'b1, 5'd0, 1'b1);
    chk("abort_pre_out", out, 32'h000003ff);
    chk("abort_pre_fill", fill_cnt, 10);
    clear = 1'b1;
    beat(1'b1, 5'd0, 1'b1);
    clear = 1'b0;
    chk("clear_abort_out", out, 0);
    chk("clear_abort_fill", fill_cnt, 0);
    beat(1'b1, 5'd0, 1'b1);
    chk("clear_abort_ptr0", out, 32'h00000001);

    // Mid-frame abort with rst
    for (int i = 0; i < 10; i++) beat(1'b1, 5'd0, 1'b1);
    chk("rst_pre_out", out, 32'h000007ff);
    chk("rst_pre_fill", fill_cnt, 11);
    rst = 1'b1;
    beat(1'b1, 5'd0, 1'b1);
    rst = 1'b0;
    chk("rst_abort_out", out, 0);
    chk("rst_abort_fill", fill_cnt, 0);
    chk("rst_abort_ready", wr_ready, 1);
    beat(1'b1, 5'd0, 1'b1);
    chk("rst_abort_ptr0", out, 32'h00000001);

    // Out-of-range select on the 24-bit instance
    beat24(5'd3, 1'b1);
    chk("w24_out3", b_out, 24'h000008);
    chk("w24_fill1", b_fill_cnt, 1);
    beat24(5'd25, 1'b1);
    chk("w24_sel_err", b_sel_err, 1);
    chk("w24_oor_out", b_out, 24'h000008);
    chk("w24_oor_fill", b_fill_cnt, 1);
    tick();
    chk("w24_sel_err_once", b_sel_err, 0);
    beat24(5'd23, 1'b1);
    chk("w24_top_out", b_out, 24'h800008);
    chk("w24_top_fill", b_fill_cnt, 2);
    chk("w24_top_sel_err", b_sel_err, 0);

`ifdef DEMUX132_READBACK_EN
    clear = 1'b1; tick(); clear = 1'b0;
    word = 32'h000c3201;
    for (int i = 0; i < 32; i++) beat(1'b1, 5'd0, word[i]);
    chk("rb_load_out", out, 32'h000c3201);
    rb_sel = 5'b10101;
    tick();
    chk("rb_bit21", rb_bit, 0);
    rb_sel = 5'd0;
    tick();
    chk("rb_bit0", rb_bit, 1);
    b_rb_sel = 5'd25;
    tick();
    chk("rb24_oor", b_rb_bit, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
